// File: rtl/arp_pkg.sv
// arp_pkg: shared constants and types for the ARP transmit scheduler.
//   ARP_OP_REQUEST / ARP_OP_REPLY : ARP operation codes driven to the sender
//   MAC_BROADCAST                 : Ethernet broadcast destination
//   arp_ctrl_state_t              : scheduler FSM states
//   arp_src_t                     : identity of the request source being served
package arp_pkg;

  localparam logic [1:0]  ARP_OP_REQUEST = 2'd1;
  localparam logic [1:0]  ARP_OP_REPLY   = 2'd2;
  localparam logic [47:0] MAC_BROADCAST  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RELEASE,
    DONE
  } arp_ctrl_state_t;

  typedef enum logic [1:0] {
    SRC_REP,
    SRC_RES,
    SRC_GARP
  } arp_src_t;

endpackage

// File: rtl/arp_tx_ctrl_garp_timer.sv
// arp_garp_timer: gratuitous-ARP period counter with a sticky pending flag.
// Only compiled when ARP_GARP_EN is defined; the scheduler instantiates it
// only in that build.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : served/aborted gratuitous frame, drops the pending flag
//   pending    : a gratuitous frame is owed
`ifdef ARP_GARP_EN
module arp_garp_timer #(
  parameter logic [31:0] GARP_PERIOD = 32'd125000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic pending
);

  logic [31:0] cnt;
  logic        tc;

  assign tc = (cnt == GARP_PERIOD - 32'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      pending <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + 32'd1;
      // A terminal count wins over a same-cycle clear so that a period that
      // elapses exactly as a frame finishes is not lost. A terminal count
      // while already pending simply leaves the flag set.
      if (tc) begin
        pending <= 1'b1;
      end else if (clear) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/arp_tx_ctrl.sv
// arp_tx_ctrl: schedules ARP replies, ARP resolves and (optionally) gratuitous
// ARPs onto a single ARP frame sender.
//
// Optional feature macro: ARP_GARP_EN (adds the periodic gratuitous source).
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_local_mac, i_local_ip    own addresses (SHA/src, SPA)
//   i_rep_req/mac/ip, o_rep_ack   reply requester (level request, 1-cycle ack)
//   i_res_req/ip, o_res_ack       resolve requester (level request, 1-cycle ack)
//   o_dst_mac..o_operation     frame fields, stable from LOAD to next LOAD
//   o_enable, i_ready          sender handshake
//   o_busy                     scheduler not idle
//   o_timeout                  1-cycle pulse when a frame is aborted
//   dbg_state                  current FSM state for observation
//
// Sender handshake: a frame starts only when i_ready is high in IDLE.
// o_enable is held high until i_ready is sampled low (sender accepted the
// frame); the frame is complete when i_ready is sampled high again. If either
// phase exceeds TIMEOUT_CYC cycles the frame is abandoned with o_timeout.
module arp_tx_ctrl
  import arp_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter logic [31:0] GARP_PERIOD = 32'd125000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [47:0]     i_local_mac,
  input  logic [31:0]     i_local_ip,
  input  logic            i_rep_req,
  input  logic [47:0]     i_rep_mac,
  input  logic [31:0]     i_rep_ip,
  output logic            o_rep_ack,
  input  logic            i_res_req,
  input  logic [31:0]     i_res_ip,
  output logic            o_res_ack,
  output logic [47:0]     o_dst_mac,
  output logic [47:0]     o_src_mac,
  output logic [47:0]     o_SHA,
  output logic [47:0]     o_THA,
  output logic [31:0]     o_SPA,
  output logic [31:0]     o_TPA,
  output logic [1:0]      o_operation,
  output logic            o_enable,
  input  logic            i_ready,
  output logic            o_busy,
  output logic            o_timeout,
  output arp_ctrl_state_t dbg_state
);

  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYC);

  arp_ctrl_state_t state, state_next;
  arp_src_t        winner, sel;
  logic            rr_last;      // 0: reply served last, 1: resolve served last
  logic [15:0]     to_cnt;
  logic            abort;
  logic            finish;       // frame ends this cycle (DONE or abort)
  logic            any_req;
  logic            garp_pending;
  logic            garp_clear;

  assign garp_clear = finish && (winner == SRC_GARP);

`ifdef ARP_GARP_EN
  arp_garp_timer #(
    .GARP_PERIOD(GARP_PERIOD)
  ) u_garp_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (garp_clear),
    .pending(garp_pending)
  );
`else
  logic unused_garp;
  assign garp_pending = 1'b0;
  assign unused_garp  = ^{GARP_PERIOD, garp_clear};
`endif

  assign any_req = i_rep_req | i_res_req | garp_pending;

  // Round-robin between reply and resolve; gratuitous only when both idle.
  always_comb begin
    sel = SRC_GARP;
    if (i_rep_req && i_res_req) begin
      sel = rr_last ? SRC_REP : SRC_RES;
    end else if (i_rep_req) begin
      sel = SRC_REP;
    end else if (i_res_req) begin
      sel = SRC_RES;
    end
  end

  assign abort  = ((state == START) || (state == RELEASE)) && (to_cnt == TO_LIMIT);
  assign finish = (state == DONE) || abort;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_ready && any_req) state_next = LOAD;
      // Requests may have been withdrawn between IDLE and LOAD; with nothing
      // left to send, fall back to IDLE rather than start an empty frame.
      LOAD:    state_next = any_req ? START : IDLE;
      START:   if (abort) state_next = IDLE;
               else if (!i_ready) state_next = RELEASE;
      RELEASE: if (abort) state_next = IDLE;
               else if (i_ready) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Phase timer: restarts on every state change, runs only while waiting on
  // the sender.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state_next != state) begin
      to_cnt <= '0;
    end else if ((state == START) || (state == RELEASE)) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner      <= SRC_REP;
      o_dst_mac   <= '0;
      o_src_mac   <= '0;
      o_SHA       <= '0;
      o_THA       <= '0;
      o_SPA       <= '0;
      o_TPA       <= '0;
      o_operation <= '0;
    end else if ((state == LOAD) && any_req) begin
      winner    <= sel;
      o_src_mac <= i_local_mac;
      o_SHA     <= i_local_mac;
      o_SPA     <= i_local_ip;
      case (sel)
        SRC_REP: begin
          o_dst_mac   <= i_rep_mac;
          o_THA       <= i_rep_mac;
          o_TPA       <= i_rep_ip;
          o_operation <= ARP_OP_REPLY;
        end
        SRC_RES: begin
          o_dst_mac   <= MAC_BROADCAST;
          o_THA       <= '0;
          o_TPA       <= i_res_ip;
          o_operation <= ARP_OP_REQUEST;
        end
        default: begin
          o_dst_mac   <= MAC_BROADCAST;
          o_THA       <= '0;
          o_TPA       <= i_local_ip;
          o_operation <= ARP_OP_REQUEST;
        end
      endcase
    end
  end

  // Only reply/resolve take part in the round-robin; gratuitous frames leave
  // the fairness state untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last <= 1'b0;
    end else if (finish && (winner == SRC_REP)) begin
      rr_last <= 1'b0;
    end else if (finish && (winner == SRC_RES)) begin
      rr_last <= 1'b1;
    end
  end

  assign o_enable  = (state == START) && !abort;
  assign o_rep_ack = finish && (winner == SRC_REP);
  assign o_res_ack = finish && (winner == SRC_RES);
  assign o_timeout = abort;
  assign o_busy    = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_arp_tx_ctrl.sv
`timescale 1ns/1ps
module tb_arp_tx_ctrl;
  import arp_pkg::*;

  localparam int unsigned TIMEOUT_CYC = 1024;
  localparam logic [31:0] GARP_PERIOD = 32'd100;
  localparam logic [47:0] LOCAL_MAC   = 48'h02AB_CDEF_0001;
  localparam logic [31:0] LOCAL_IP    = 32'hC0A8_0101;
  localparam logic [1:0]  K_REP  = 2'd0;
  localparam logic [1:0]  K_RES  = 2'd1;
  localparam logic [1:0]  K_NONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;  // which ack must end the frame
    logic        to;    // frame must end in timeout
    logic [1:0]  op;
    logic [47:0] dst;
    logic [47:0] tha;
    logic [31:0] tpa;
  } exp_t;
  localparam int W = $bits(exp_t);
  logic [W-1:0] exp_q[$];

  // ---------------- clock / reset / DUT ----------------
  logic clk, rst_n;
  logic [47:0] i_local_mac, i_rep_mac;
  logic [31:0] i_local_ip, i_rep_ip, i_res_ip;
  logic i_rep_req, i_res_req, i_ready;
  logic o_rep_ack, o_res_ack, o_enable, o_busy, o_timeout;
  logic [47:0] o_dst_mac, o_src_mac, o_SHA, o_THA;
  logic [31:0] o_SPA, o_TPA;
  logic [1:0]  o_operation;
  arp_ctrl_state_t dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  arp_tx_ctrl #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .GARP_PERIOD(GARP_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .i_local_mac(i_local_mac), .i_local_ip(i_local_ip),
    .i_rep_req(i_rep_req), .i_rep_mac(i_rep_mac), .i_rep_ip(i_rep_ip),
    .o_rep_ack(o_rep_ack),
    .i_res_req(i_res_req), .i_res_ip(i_res_ip), .o_res_ack(o_res_ack),
    .o_dst_mac(o_dst_mac), .o_src_mac(o_src_mac), .o_SHA(o_SHA), .o_THA(o_THA),
    .o_SPA(o_SPA), .o_TPA(o_TPA), .o_operation(o_operation),
    .o_enable(o_enable), .i_ready(i_ready), .o_busy(o_busy),
    .o_timeout(o_timeout), .dbg_state(dbg_state)
  );

  // ---------------- checking helpers ----------------
  int compared   = 0;
  int mismatched = 0;
  int frames_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    compared++;
    mismatched++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  function automatic void push(input logic [1:0] kind, input logic to, input logic [1:0] op,
                               input logic [47:0] dst, input logic [47:0] tha,
                               input logic [31:0] tpa);
    exp_t e;
    e.kind = kind; e.to = to; e.op = op; e.dst = dst; e.tha = tha; e.tpa = tpa;
    exp_q.push_back(e);
  endfunction

  function automatic void push_rep(input logic [1:0] kind, input logic to,
                                   input logic [47:0] mac, input logic [31:0] ip);
    push(kind, to, 2'd2, mac, mac, ip);
  endfunction

  function automatic void push_res(input logic [31:0] ip);
    push(K_RES, 1'b0, 2'd1, 48'hFFFF_FFFF_FFFF, 48'h0, ip);
  endfunction

  // ---------------- sender model ----------------
  // ready falls one cycle after enable is seen; frame ends 260 cycles after
  // enable drops. With stuck set, ready never drops.
  bit stuck = 1'b0;
  initial begin
    bit gone;
    i_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (o_enable && i_ready && !stuck) begin
        @(posedge clk);
        #1 i_ready = 1'b0;
        gone = 1'b0;
        for (int n = 0; n < 2000 && !gone; n++) begin
          @(negedge clk);
          gone = !o_enable;
        end
        repeat (260) @(posedge clk);
        #1 i_ready = 1'b1;
      end
    end
  end

  // ---------------- requester drivers ----------------
  task automatic wait_ack(input bit is_rep);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 5000 && !got; n++) begin
      @(negedge clk);
      got = is_rep ? o_rep_ack : o_res_ack;
    end
    if (!got) fail_now(is_rep ? "rep_ack_wait" : "res_ack_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic rep_session(input logic [47:0] m0, input logic [31:0] ip0,
                             input logic [47:0] m1, input logic [31:0] ip1, input int n);
    i_rep_mac = m0; i_rep_ip = ip0; i_rep_req = 1'b1;
    wait_ack(1'b1);
    if (n > 1) begin
      i_rep_mac = m1; i_rep_ip = ip1;
      wait_ack(1'b1);
    end
    i_rep_req = 1'b0;
  endtask

  task automatic res_session(input logic [31:0] ip0, input logic [31:0] ip1, input int n);
    i_res_ip = ip0; i_res_req = 1'b1;
    wait_ack(1'b0);
    if (n > 1) begin
      i_res_ip = ip1;
      wait_ack(1'b0);
    end
    i_res_req = 1'b0;
  endtask

  task automatic wait_enable(input logic level, input string name);
    bit hit;
    hit = 1'b0;
    for (int n = 0; n < 3000 && !hit; n++) begin
      @(negedge clk);
      hit = (o_enable == level);
    end
    if (!hit) fail_now(name);
  endtask

  task automatic reset_mid_release();
    wait_enable(1'b1, "rst_wait_enable_high");
    wait_enable(1'b0, "rst_wait_enable_low");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_enable", {63'd0, o_enable}, 64'd0);
    check("rst_mid_busy", {63'd0, o_busy}, 64'd0);
    @(negedge clk);
    check("rst_mid_no_ack", {62'd0, o_rep_ack, o_res_ack}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    bit   in_frame, prev_en;
    exp_t cur;
    int   en_cnt, rep_cnt, res_cnt, to_cnt, cyc, start_cyc;
    in_frame = 1'b0; prev_en = 1'b0; cyc = 0;
    en_cnt = 0; rep_cnt = 0; res_cnt = 0; to_cnt = 0; start_cyc = 0;
    cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (o_enable && !prev_en && !in_frame) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          cur = exp_q.pop_front();
          check("operation", {62'd0, o_operation}, {62'd0, cur.op});
          check("dst_mac", {16'd0, o_dst_mac}, {16'd0, cur.dst});
          check("tha", {16'd0, o_THA}, {16'd0, cur.tha});
          check("tpa", {32'd0, o_TPA}, {32'd0, cur.tpa});
          check("src_mac", {16'd0, o_src_mac}, {16'd0, LOCAL_MAC});
          check("sha", {16'd0, o_SHA}, {16'd0, LOCAL_MAC});
          check("spa", {32'd0, o_SPA}, {32'd0, LOCAL_IP});
          in_frame = 1'b1;
          en_cnt = 0; rep_cnt = 0; res_cnt = 0; to_cnt = 0;
          start_cyc = cyc;
        end
      end else if (!in_frame && (o_rep_ack || o_res_ack || o_timeout)) begin
        fail_now("stray_pulse");
      end
      if (in_frame) begin
        if (o_enable) en_cnt++;
        if (o_rep_ack) rep_cnt++;
        if (o_res_ack) res_cnt++;
        if (o_timeout) begin
          to_cnt++;
          check("timeout_enable_low", {63'd0, o_enable}, 64'd0);
          check("timeout_ack_same_cycle", {63'd0, o_rep_ack | o_res_ack}, 64'd1);
          check("timeout_latency", 64'(cyc - start_cyc), 64'(TIMEOUT_CYC));
        end
        if (!o_busy) begin
          check("rep_ack_count", 64'(rep_cnt), (cur.kind == K_REP) ? 64'd1 : 64'd0);
          check("res_ack_count", 64'(res_cnt), (cur.kind == K_RES) ? 64'd1 : 64'd0);
          check("timeout_count", 64'(to_cnt), {63'd0, cur.to});
          check("enable_cycles", 64'(en_cnt), cur.to ? 64'(TIMEOUT_CYC) : 64'd2);
          in_frame = 1'b0;
          frames_done++;
        end
      end
      prev_en = o_enable;
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    int exp_frames;
    rst_n = 1'b0;
    i_local_mac = LOCAL_MAC; i_local_ip = LOCAL_IP;
    i_rep_req = 1'b0; i_rep_mac = '0; i_rep_ip = '0;
    i_res_req = 1'b0; i_res_ip = '0;
    repeat (3) @(negedge clk);
    check("reset_enable", {63'd0, o_enable}, 64'd0);
    check("reset_busy", {63'd0, o_busy}, 64'd0);
    check("reset_acks", {61'd0, o_rep_ack, o_res_ack, o_timeout}, 64'd0);
    check("reset_operation", {62'd0, o_operation}, 64'd0);
    check("reset_dst_mac", {16'd0, o_dst_mac}, 64'd0);
    check("reset_tpa", {32'd0, o_TPA}, 64'd0);
    check("reset_state", {61'd0, dbg_state}, {61'd0, IDLE});
    @(negedge clk);
    rst_n = 1'b1;

`ifdef ARP_GARP_EN
    // Gratuitous frame first; a reply raised during it is served, and held
    // for a second frame it beats the gratuitous that became pending meanwhile.
    push(K_NONE, 1'b0, 2'd1, 48'hFFFF_FFFF_FFFF, 48'h0, LOCAL_IP);
    push_rep(K_REP, 1'b0, 48'h0011_2233_4455, 32'hC0A8_0102);
    push_rep(K_REP, 1'b0, 48'h0066_7788_99AA, 32'hC0A8_0103);
    push(K_NONE, 1'b0, 2'd1, 48'hFFFF_FFFF_FFFF, 48'h0, LOCAL_IP);
    exp_frames = 4;
    wait_enable(1'b1, "garp_first_frame");
    rep_session(48'h0011_2233_4455, 32'hC0A8_0102, 48'h0066_7788_99AA, 32'hC0A8_0103, 2);
`else
    // Reply only
    push_rep(K_REP, 1'b0, 48'h0011_2233_4455, 32'hC0A8_0102);
    rep_session(48'h0011_2233_4455, 32'hC0A8_0102, 48'h0, 32'h0, 1);
    // Resolve only
    push_res(32'hC0A8_01FE);
    res_session(32'hC0A8_01FE, 32'h0, 1);
    // Both held: resolve went last, so reply leads and they alternate
    push_rep(K_REP, 1'b0, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001);
    push_res(32'h0A00_0002);
    push_rep(K_REP, 1'b0, 48'h1111_2222_3333, 32'h0A00_0003);
    push_res(32'h0A00_0004);
    fork
      rep_session(48'h0A0B_0C0D_0E0F, 32'h0A00_0001, 48'h1111_2222_3333, 32'h0A00_0003, 2);
      res_session(32'h0A00_0002, 32'h0A00_0004, 2);
    join
    // Sender never accepts: abort after TIMEOUT_CYC cycles in START
    stuck = 1'b1;
    push_rep(K_REP, 1'b1, 48'h0BAD_0BAD_0BAD, 32'h0A00_00FF);
    rep_session(48'h0BAD_0BAD_0BAD, 32'h0A00_00FF, 48'h0, 32'h0, 1);
    stuck = 1'b0;
    // Reset during RELEASE: frame vanishes without ack, then is re-served
    push_rep(K_NONE, 1'b0, 48'h00CA_FE00_BEEF, 32'hC0A8_0150);
    push_rep(K_REP, 1'b0, 48'h00CA_FE00_BEEF, 32'hC0A8_0150);
    fork
      rep_session(48'h00CA_FE00_BEEF, 32'hC0A8_0150, 48'h0, 32'h0, 1);
      reset_mid_release();
    join
    exp_frames = 9;
`endif

    for (int n = 0; n < 3000 && frames_done < exp_frames; n++) @(negedge clk);
    check("frames_seen", 64'(frames_done), 64'(exp_frames));
    check("queue_left", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
